// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared state encoding and default watchdog limit for the MFCC sequencer
package mfcc_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FRM  = 3'd2,
    FFT  = 3'd3,
    MEL  = 3'd4,
    DCT  = 3'd5,
    DONE = 3'd6
  } state_t;
  localparam logic [19:0] DEF_TIMEOUT = 20'hF_FFFF;
endpackage

// File: rtl/mfcc_stage_wdog.sv
// mfcc_stage_wdog: per-stage wait counter, cleared by each start pulse, flags expiry
module mfcc_stage_wdog import mfcc_pkg::*; #(
  parameter int TO_W = 20,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(DEF_TIMEOUT)
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic start,
  input  logic wait_en,
  output logic expired
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // count waiting cycles since the last start pulse
  always_comb cnt_d = start ? '0 : wait_en ? cnt_q + TO_W'(1) : cnt_q;
  // counter register
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // the TIMEOUT-th waiting cycle is the last one allowed
  assign expired = wait_en & (cnt_q == TIMEOUT - TO_W'(1));
endmodule

// File: rtl/mfcc_seq_ctrl.sv
// mfcc_seq_ctrl: frame sequencer driving framing, FFT passes, mel and DCT stages
module mfcc_seq_ctrl import mfcc_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int FFT_W = 8,
  parameter int TO_W = 20,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(DEF_TIMEOUT)
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             trigger,
  input  logic [31:0]      frame_num,
  input  logic [31:0]      fft_num,
  output logic             frm_start,
  input  logic             frm_done,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             mel_start,
  input  logic             mel_done,
  output logic             dct_start,
  input  logic             dct_done,
  output logic [CNT_W-1:0] frame_idx,
  output logic [FFT_W-1:0] fft_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [2:0]       state
);
  state_t state_q, state_d;
  logic trig_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, frame_idx_q, frame_idx_d;
  logic [FFT_W-1:0] fft_max_q, fft_max_d, fft_idx_q, fft_idx_d;
  logic frm_start_q, frm_start_d, fft_start_q, fft_start_d;
  logic mel_start_q, mel_start_d, dct_start_q, dct_start_d;
  logic busy_q, busy_d, done_q, done_d, timeout_err_q, timeout_err_d;
  logic rise, stage_start, waiting, stage_done, accept, expired, abort, tmo;
  logic unused_hi;
  assign unused_hi = ^{frame_num[31:CNT_W], fft_num[31:FFT_W]};
  assign rise = trigger & ~trig_q;
  assign stage_start = frm_start_q | fft_start_q | mel_start_q | dct_start_q;
  assign waiting = (state_q inside {FRM, FFT, MEL, DCT}) & ~stage_start;
  assign stage_done = (state_q == FRM & frm_done) | (state_q == FFT & fft_done) |
                      (state_q == MEL & mel_done) | (state_q == DCT & dct_done);
  assign accept = waiting & stage_done;
  assign abort = (state_q != IDLE) & ~trigger;
  assign tmo = expired & ~accept & ~abort;
  mfcc_stage_wdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_wdog (
    .hclk    (hclk),
    .hresetn (hresetn),
    .start   (stage_start),
    .wait_en (waiting),
    .expired (expired)
  );
  // next state, stage start pulses, counters and status
  always_comb begin
    state_d = state_q;
    frame_cnt_d = frame_cnt_q;
    fft_max_d = fft_max_q;
    frame_idx_d = frame_idx_q;
    fft_idx_d = fft_idx_q;
    frm_start_d = 1'b0;
    fft_start_d = 1'b0;
    mel_start_d = 1'b0;
    dct_start_d = 1'b0;
    done_d = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: if (rise) begin
        state_d = LOAD;
        timeout_err_d = 1'b0;
      end
      LOAD: begin
        frame_cnt_d = frame_num[CNT_W-1:0];
        fft_max_d = (fft_num[FFT_W-1:0] == '0) ? '0 : fft_num[FFT_W-1:0] - FFT_W'(1);
        frame_idx_d = '0;
        fft_idx_d = '0;
        state_d = (frame_num[CNT_W-1:0] == '0) ? DONE : FRM;
        done_d = frame_num[CNT_W-1:0] == '0;
        frm_start_d = frame_num[CNT_W-1:0] != '0;
      end
      FRM: if (accept) begin
        state_d = FFT;
        fft_start_d = 1'b1;
      end
      FFT: if (accept) begin
        if (fft_idx_q == fft_max_q) begin
          fft_idx_d = '0;
          state_d = MEL;
          mel_start_d = 1'b1;
        end else begin
          fft_idx_d = fft_idx_q + FFT_W'(1);
          fft_start_d = 1'b1;
        end
      end
      MEL: if (accept) begin
        state_d = DCT;
        dct_start_d = 1'b1;
      end
      DCT: if (accept) begin
        if (frame_idx_q == frame_cnt_q - CNT_W'(1)) begin
          state_d = DONE;
          done_d = 1'b1;
        end else begin
          frame_idx_d = frame_idx_q + CNT_W'(1);
          state_d = FRM;
          frm_start_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        frame_idx_d = '0;
        fft_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort | tmo) begin
      state_d = IDLE;
      frm_start_d = 1'b0;
      fft_start_d = 1'b0;
      mel_start_d = 1'b0;
      dct_start_d = 1'b0;
      done_d = 1'b0;
      frame_idx_d = '0;
      fft_idx_d = '0;
    end
    if (tmo) timeout_err_d = 1'b1;
    busy_d = state_d inside {LOAD, FRM, FFT, MEL, DCT};
  end
  // state and output registers
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state_q <= IDLE;
      trig_q <= 1'b0;
      frame_cnt_q <= '0;
      fft_max_q <= '0;
      frame_idx_q <= '0;
      fft_idx_q <= '0;
      frm_start_q <= 1'b0;
      fft_start_q <= 1'b0;
      mel_start_q <= 1'b0;
      dct_start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q <= trigger;
      frame_cnt_q <= frame_cnt_d;
      fft_max_q <= fft_max_d;
      frame_idx_q <= frame_idx_d;
      fft_idx_q <= fft_idx_d;
      frm_start_q <= frm_start_d;
      fft_start_q <= fft_start_d;
      mel_start_q <= mel_start_d;
      dct_start_q <= dct_start_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  assign frm_start = frm_start_q;
  assign fft_start = fft_start_q;
  assign mel_start = mel_start_q;
  assign dct_start = dct_start_q;
  assign frame_idx = frame_idx_q;
  assign fft_idx = fft_idx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign timeout_err = timeout_err_q;
  assign state = state_q;
endmodule

// File: tb/tb_mfcc_seq_ctrl.sv
// tb_mfcc_seq_ctrl: directed checks of the MFCC sequencer with auto-responding stages
module tb_mfcc_seq_ctrl;
  logic hclk = 1'b0, hresetn = 1'b0, trigger = 1'b0;
  logic [31:0] frame_num = '0, fft_num = '0;
  logic frm_start, fft_start, mel_start, dct_start, busy, done, timeout_err;
  logic [15:0] frame_idx;
  logic [7:0] fft_idx;
  logic [2:0] state;
  bit [3:0] r_done;
  logic [3:0] m_done = '0;
  bit hold_fft;
  int rc [4];
  int log_q[$];
  int done_cnt;
  int tests, fails;
  logic [3:0] st;
  assign st = {dct_start, mel_start, fft_start, frm_start};
  always #5 hclk = ~hclk;
  mfcc_seq_ctrl #(.TIMEOUT(20'd16)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .trigger     (trigger),
    .frame_num   (frame_num),
    .fft_num     (fft_num),
    .frm_start   (frm_start),
    .frm_done    (r_done[0] | m_done[0]),
    .fft_start   (fft_start),
    .fft_done    (r_done[1] | m_done[1]),
    .mel_start   (mel_start),
    .mel_done    (r_done[2] | m_done[2]),
    .dct_start   (dct_start),
    .dct_done    (r_done[3] | m_done[3]),
    .frame_idx   (frame_idx),
    .fft_idx     (fft_idx),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .state       (state)
  );
  function automatic int enc(input int c, input int f, input int x);
    return c * 65536 + f * 256 + x;
  endfunction
  // each stage answers with a one-cycle done five cycles after its start pulse
  always @(negedge hclk)
    for (int s = 0; s < 4; s++) begin
      if (st[s]) rc[s] <= 5;
      else if (rc[s] > 0) rc[s] <= rc[s] - 1;
      r_done[s] <= !st[s] && rc[s] == 1 && !(s == 1 && hold_fft);
    end
  // record every start pulse with the indices seen alongside it, and count done pulses
  always @(posedge hclk) begin
    #2;
    if (frm_start) log_q.push_back(enc(2, int'(frame_idx), int'(fft_idx)));
    if (fft_start) log_q.push_back(enc(3, int'(frame_idx), int'(fft_idx)));
    if (mel_start) log_q.push_back(enc(4, int'(frame_idx), int'(fft_idx)));
    if (dct_start) log_q.push_back(enc(5, int'(frame_idx), int'(fft_idx)));
    if (done) done_cnt <= done_cnt + 1;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge hclk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_state(input string tag, input logic [2:0] s);
    for (int i = 0; i < 300 && state !== s; i++) tick();
    chk(tag, 32'(state), 32'(s));
  endtask
  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    chk(tag, 32'(done), 32'd1);
  endtask
  initial begin
    int b, d, n;
    int e1 [8];
    int e2 [6];
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({frm_start, fft_start, mel_start, dct_start, done, timeout_err}), 32'd0);
    hresetn = 1'b1;
    tick();
    frame_num = 2; fft_num = 1; b = log_q.size(); d = done_cnt; trigger = 1'b1;
    tick();
    chk("t1_load", 32'(state), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_frm", 32'(state), 32'd2);
    chk("t1_frm_start", 32'(frm_start), 32'd1);
    tick();
    chk("t1_frm_pulse", 32'(frm_start), 32'd0);
    wait_done("t1_done", d);
    chk("t1_done_state", 32'(state), 32'd6);
    chk("t1_done_busy", 32'(busy), 32'd0);
    tick(3);
    chk("t1_one_done", 32'(done_cnt - d), 32'd1);
    chk("t1_idle", 32'(state), 32'd0);
    e1 = '{enc(2,0,0), enc(3,0,0), enc(4,0,0), enc(5,0,0), enc(2,1,0), enc(3,1,0), enc(4,1,0), enc(5,1,0)};
    chk("t1_nstarts", 32'(log_q.size() - b), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_start%0d", i), 32'(log_q[b + i]), 32'(e1[i]));
    trigger = 1'b0;
    tick(2);
    frame_num = 1; fft_num = 3; b = log_q.size(); d = done_cnt; trigger = 1'b1;
    wait_done("t2_done", d);
    tick(3);
    e2 = '{enc(2,0,0), enc(3,0,0), enc(3,0,1), enc(3,0,2), enc(4,0,0), enc(5,0,0)};
    chk("t2_nstarts", 32'(log_q.size() - b), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_start%0d", i), 32'(log_q[b + i]), 32'(e2[i]));
    trigger = 1'b0;
    tick(2);
    frame_num = 0; b = log_q.size(); d = done_cnt; trigger = 1'b1;
    tick();
    chk("t3_load", 32'(state), 32'd1);
    tick();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_done_state", 32'(state), 32'd6);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_done_pulse", 32'(done), 32'd0);
    chk("t3_idle", 32'(state), 32'd0);
    chk("t3_nostart", 32'(log_q.size() - b), 32'd0);
    trigger = 1'b0;
    tick(2);
    frame_num = 4; fft_num = 1; d = done_cnt; trigger = 1'b1;
    wait_state("t4_mel0", 3'd4);
    wait_state("t4_dct0", 3'd5);
    wait_state("t4_mel1", 3'd4);
    chk("t4_fidx", 32'(frame_idx), 32'd1);
    tick(2);
    trigger = 1'b0;
    b = log_q.size();
    tick();
    chk("t4_abort_state", 32'(state), 32'd0);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_fidx", 32'(frame_idx), 32'd0);
    m_done[2] = 1'b1;
    tick();
    m_done[2] = 1'b0;
    tick(8);
    chk("t4_nostart", 32'(log_q.size() - b), 32'd0);
    chk("t4_nodone", 32'(done_cnt - d), 32'd0);
    chk("t4_idle", 32'(state), 32'd0);
    hold_fft = 1'b1; frame_num = 1; fft_num = 1; d = done_cnt; trigger = 1'b1;
    wait_state("t5_fft", 3'd3);
    chk("t5_fft_start", 32'(fft_start), 32'd1);
    tick(16);
    chk("t5_not_yet", 32'(timeout_err), 32'd0);
    chk("t5_still_fft", 32'(state), 32'd3);
    tick();
    chk("t5_tmo", 32'(timeout_err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_nodone", 32'(done_cnt - d), 32'd0);
    trigger = 1'b0; hold_fft = 1'b0;
    tick(3);
    chk("t5_sticky", 32'(timeout_err), 32'd1);
    frame_num = 0; trigger = 1'b1;
    tick();
    chk("t5_clear", 32'(timeout_err), 32'd0);
    tick(2);
    trigger = 1'b0;
    tick(2);
    frame_num = 2; fft_num = 1; b = log_q.size(); d = done_cnt; trigger = 1'b1;
    tick(3);
    chk("t6_frm", 32'(state), 32'd2);
    frame_num = 9; m_done[1] = 1'b1;
    tick();
    m_done[1] = 1'b0;
    chk("t6_stray", 32'(state), 32'd2);
    wait_done("t6_done", d);
    n = 0;
    for (int i = b; i < log_q.size(); i++) if (log_q[i] / 65536 == 2) n++;
    chk("t6_frames", 32'(n), 32'd2);
    trigger = 1'b0;
    tick(2);
    frame_num = 1; fft_num = 3; trigger = 1'b1;
    wait_state("t6_fft", 3'd3);
    for (int i = 0; i < 50 && fft_idx !== 8'd1; i++) tick();
    chk("t6_fidx1", 32'(fft_idx), 32'd1);
    chk("t6_busy", 32'(busy), 32'd1);
    hresetn = 1'b0; trigger = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_idx", 32'({frame_idx, fft_idx}), 32'd0);
    chk("t6_rst_outs", 32'({frm_start, fft_start, mel_start, dct_start, done, timeout_err}), 32'd0);
    tick(2);
    hresetn = 1'b1;
    tick(10);
    chk("t6_rel_idle", 32'(state), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
